// File: rtl/sig_triplet_fifo_if.sv
// Handshake bundle between the signal-assign stage, the triplet FIFO and its downstream sink.
// A word moves on a rising edge when valid and ready are both 1; valid never waits on ready.
interface sig_triplet_fifo_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sig_triplet_fifo.sv
// First-word-fall-through FIFO for packed {x,y,z} words, with occupancy count and a
// sticky overflow flag that records any word offered while full.
module sig_triplet_fifo #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  sig_triplet_fifo_if.slave    bus,
  output logic [CW-1:0]        count,
  output logic                 overflow
);

  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Both ready and valid come from count alone, so neither side sees the other combinationally.
  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 3'b000;
      end
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= FULL);
      assert (!(push && !pop && count == FULL));
      assert (!(pop && !push && count == '0));
    end
  end

endmodule
